// File: rtl/beeper_sequencer.sv
// beeper_sequencer: plays queued notes on the Beeper's one-hot key bus.
// Notes arrive over a valid/ready handshake. Each note lasts a number of beats
// and is followed by a silent gap. Live keys preempt playback. After the keys
// are released, a holdoff runs, and the frozen note then resumes where it stopped.
// Optional build macro: BEEPER_SEQ_LEGATO_EN removes the gap and chains notes
// directly on the final tick of a note.
module beeper_sequencer #(
    parameter int TICK_DIV     = 12000,
    parameter int BEAT_TICKS   = 125,
    parameter int GAP_TICKS    = 10,
    parameter int RESUME_TICKS = 200
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic [15:0] key_in,
    input  logic        note_valid,
    output logic        note_ready,
    input  logic [4:0]  note_code,
    input  logic [3:0]  note_beats,
    input  logic        play_en,
    input  logic        abort,
    output logic [15:0] key_out,
    output logic        busy,
    output logic        live_active
);

    localparam int TMAX = (15 * BEAT_TICKS > GAP_TICKS) ? 15 * BEAT_TICKS : GAP_TICKS;
    localparam int TW   = $clog2(TMAX + 1);
    localparam int PW   = $clog2(TICK_DIV);
    localparam int HW   = $clog2(RESUME_TICKS + 1);

    typedef enum logic [1:0] {ST_IDLE, ST_NOTE, ST_GAP} state_t;

    state_t          state_reg, state_next;
    logic [TW-1:0]   tick_cnt_reg, tick_cnt_next;
    logic [PW-1:0]   pre_cnt_reg, pre_cnt_next;
    logic [3:0]      idx_reg, idx_next;
    logic            rest_reg, rest_next;
    logic [HW-1:0]   hold_cnt_reg, hold_cnt_next;
    logic [PW-1:0]   hold_pre_reg, hold_pre_next;
    logic [15:0]     key_out_reg, key_out_next;
    logic            busy_reg, live_active_reg;

    logic            keys_live, pause, play_tick, last_tick, accept;
    logic [3:0]      beats_eff;
    logic [15:0]     play_key;

    assign keys_live = |key_in;
    assign pause     = keys_live | (hold_cnt_reg != '0);
    assign play_tick = ~pause & (pre_cnt_reg == PW'(TICK_DIV - 1));
    assign last_tick = (state_reg == ST_NOTE) & play_tick & (tick_cnt_reg <= TW'(1));
    assign beats_eff = (note_beats == 4'd0) ? 4'd1 : note_beats;

`ifdef BEEPER_SEQ_LEGATO_EN
    assign note_ready = ((state_reg == ST_IDLE) | last_tick) & play_en & ~pause & ~abort;
`else
    assign note_ready = (state_reg == ST_IDLE) & play_en & ~pause & ~abort;
`endif
    assign accept = note_valid & note_ready;

    // Play FSM next state: abort wins, then acceptance, then tick-driven progress (frozen on pause).
    always_comb begin
        state_next    = state_reg;
        tick_cnt_next = tick_cnt_reg;
        pre_cnt_next  = pre_cnt_reg;
        idx_next      = idx_reg;
        rest_next     = rest_reg;
        if (abort) begin
            state_next    = ST_IDLE;
            tick_cnt_next = '0;
            pre_cnt_next  = '0;
        end else if (accept) begin
            state_next    = ST_NOTE;
            tick_cnt_next = TW'(int'(beats_eff) * BEAT_TICKS);
            pre_cnt_next  = '0;
            idx_next      = note_code[3:0];
            rest_next     = note_code[4];
        end else if (!pause && state_reg != ST_IDLE) begin
            pre_cnt_next = play_tick ? '0 : pre_cnt_reg + PW'(1);
            if (play_tick) begin
                case (state_reg)
                    ST_NOTE: begin
                        if (last_tick) begin
`ifdef BEEPER_SEQ_LEGATO_EN
                            state_next    = ST_IDLE;
                            tick_cnt_next = '0;
`else
                            state_next    = ST_GAP;
                            tick_cnt_next = TW'(GAP_TICKS);
`endif
                        end else begin
                            tick_cnt_next = tick_cnt_reg - TW'(1);
                        end
                    end
                    ST_GAP: begin
                        if (tick_cnt_reg <= TW'(1)) begin
                            state_next    = ST_IDLE;
                            tick_cnt_next = '0;
                        end else begin
                            tick_cnt_next = tick_cnt_reg - TW'(1);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Live path: held keys reload the holdoff; after release it counts down on its own prescaler.
    always_comb begin
        hold_cnt_next = hold_cnt_reg;
        hold_pre_next = hold_pre_reg;
        if (keys_live) begin
            hold_cnt_next = HW'(RESUME_TICKS);
            hold_pre_next = '0;
        end else if (hold_cnt_reg != '0) begin
            if (hold_pre_reg == PW'(TICK_DIV - 1)) begin
                hold_pre_next = '0;
                hold_cnt_next = hold_cnt_reg - HW'(1);
            end else begin
                hold_pre_next = hold_pre_reg + PW'(1);
            end
        end else begin
            hold_pre_next = '0;
        end
    end

    // Key bus mux: live keys, then silence during holdoff, then the tone of the upcoming play state.
    always_comb begin
        play_key = '0;
        if (state_next == ST_NOTE && !rest_next) begin
            play_key = 16'h0001 << idx_next;
        end
        if (keys_live) begin
            key_out_next = key_in;
        end else if (hold_cnt_next != '0) begin
            key_out_next = '0;
        end else begin
            key_out_next = play_key;
        end
    end

    // State and output registers.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_reg       <= ST_IDLE;
            tick_cnt_reg    <= '0;
            pre_cnt_reg     <= '0;
            idx_reg         <= '0;
            rest_reg        <= 1'b0;
            hold_cnt_reg    <= '0;
            hold_pre_reg    <= '0;
            key_out_reg     <= '0;
            busy_reg        <= 1'b0;
            live_active_reg <= 1'b0;
        end else begin
            state_reg       <= state_next;
            tick_cnt_reg    <= tick_cnt_next;
            pre_cnt_reg     <= pre_cnt_next;
            idx_reg         <= idx_next;
            rest_reg        <= rest_next;
            hold_cnt_reg    <= hold_cnt_next;
            hold_pre_reg    <= hold_pre_next;
            key_out_reg     <= key_out_next;
            busy_reg        <= (state_next != ST_IDLE);
            live_active_reg <= pause;
        end
    end

    assign key_out     = key_out_reg;
    assign busy        = busy_reg;
    assign live_active = live_active_reg;

endmodule

// File: tb/tb_beeper_sequencer.sv
// Directed bench for beeper_sequencer with TICK_DIV=4, BEAT_TICKS=3, GAP_TICKS=2,
// RESUME_TICKS=5. Inputs change 2 ns after a rising edge. Outputs are checked
// in the same cycle, away from the edge.
module tb_beeper_sequencer;

    logic        clk_in = 1'b0;
    logic        rst_n_in;
    logic [15:0] key_in;
    logic        note_valid;
    logic        note_ready;
    logic [4:0]  note_code;
    logic [3:0]  note_beats;
    logic        play_en;
    logic        abort;
    logic [15:0] key_out;
    logic        busy;
    logic        live_active;

    int n_vec = 0;
    int n_err = 0;

    beeper_sequencer #(
        .TICK_DIV(4), .BEAT_TICKS(3), .GAP_TICKS(2), .RESUME_TICKS(5)
    ) dut (
        .clk_in(clk_in), .rst_n_in(rst_n_in), .key_in(key_in),
        .note_valid(note_valid), .note_ready(note_ready), .note_code(note_code),
        .note_beats(note_beats), .play_en(play_en), .abort(abort),
        .key_out(key_out), .busy(busy), .live_active(live_active)
    );

    always #5 clk_in = ~clk_in;

    task automatic adv(input int n);
        repeat (n) @(posedge clk_in);
        #2;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
        $display("check %-14s observed %h expected %h", tag, obs, exp);
    endtask

    // Present a note, confirm ready, take the accepting edge, drop valid.
    task automatic send(input string tag, input logic [4:0] code, input logic [3:0] beats);
        note_code  = code;
        note_beats = beats;
        note_valid = 1'b1;
        #1;
        chk(tag, {15'd0, note_ready}, 16'h0001);
        adv(1);
        note_valid = 1'b0;
    endtask

    initial begin
        rst_n_in = 1'b0; key_in = '0; note_valid = 1'b0; note_code = '0;
        note_beats = '0; play_en = 1'b0; abort = 1'b0;
        adv(2);
        chk("rst_key", key_out, 16'h0000);
        chk("rst_busy", {15'd0, busy}, 16'h0000);
        chk("rst_live", {15'd0, live_active}, 16'h0000);
        chk("rst_ready", {15'd0, note_ready}, 16'h0000);
        rst_n_in = 1'b1;
        adv(1);
        play_en = 1'b1;

        // 1: idx 5, 2 beats -> 24 tone cycles, 8 gap cycles
        send("t1_acc", 5'd5, 4'd2);                      // now T+1
        chk("t1_first", key_out, 16'h0020);
        chk("t1_busy", {15'd0, busy}, 16'h0001);
        chk("t1_nrdy", {15'd0, note_ready}, 16'h0000);
        adv(23); chk("t1_last", key_out, 16'h0020);      // T+24
        adv(1);  chk("t1_gap0", key_out, 16'h0000);      // T+25
        adv(7);  chk("t1_gapend", key_out, 16'h0000);    // T+32
        chk("t1_gbusy", {15'd0, busy}, 16'h0001);
        adv(1);  chk("t1_idle", {15'd0, busy}, 16'h0000);// T+33
        chk("t1_ready", {15'd0, note_ready}, 16'h0001);

        // 2: beats=0 acts as one beat; rest note is silent but busy
        send("t2_acc", 5'd15, 4'd0);
        chk("t2_first", key_out, 16'h8000);
        adv(11); chk("t2_last", key_out, 16'h8000);
        adv(1);  chk("t2_after", key_out, 16'h0000);
        adv(8);  chk("t2_idle", {15'd0, busy}, 16'h0000);
        send("t2_racc", 5'h10, 4'd1);
        chk("t2_rkey", key_out, 16'h0000);
        chk("t2_rbusy", {15'd0, busy}, 16'h0001);
        adv(19); chk("t2_rkey20", key_out, 16'h0000);
        chk("t2_rbusy20", {15'd0, busy}, 16'h0001);
        adv(1);  chk("t2_ridle", {15'd0, busy}, 16'h0000);

        // 3: live keys preempt idx 2 after 7 tone cycles
        send("t3_acc", 5'd2, 4'd2);                      // T+1
        adv(6);  chk("t3_pre", key_out, 16'h0004);       // T+7
        adv(1);  chk("t3_lag", key_out, 16'h0004);       // T+8
        key_in = 16'h0101;
        #1; chk("t3_blk", {15'd0, note_ready}, 16'h0000);
        adv(1);  chk("t3_live", key_out, 16'h0101);      // T+9
        chk("t3_lact", {15'd0, live_active}, 16'h0001);
        adv(9);  chk("t3_live10", key_out, 16'h0101);    // T+18
        key_in = 16'h0000;
        adv(1);  chk("t3_hold0", key_out, 16'h0000);     // T+19
        chk("t3_hlact", {15'd0, live_active}, 16'h0001);
        adv(18); chk("t3_hold19", key_out, 16'h0000);    // T+37
        adv(1);  chk("t3_resume", key_out, 16'h0004);    // T+38
        chk("t3_lact38", {15'd0, live_active}, 16'h0001);
        adv(1);  chk("t3_ldrop", {15'd0, live_active}, 16'h0000);
        adv(15); chk("t3_tail", key_out, 16'h0004);      // T+54
        adv(1);  chk("t3_gap", key_out, 16'h0000);       // T+55
        adv(8);  chk("t3_idle", {15'd0, busy}, 16'h0000);

        // 4: abort mid-note blocks a same-cycle accept
        send("t4_acc", 5'd3, 4'd1);
        adv(4);  chk("t4_mid", key_out, 16'h0008);
        abort = 1'b1; note_valid = 1'b1; note_code = 5'd7; note_beats = 4'd1;
        #1; chk("t4_blk", {15'd0, note_ready}, 16'h0000);
        adv(1);
        abort = 1'b0;
        chk("t4_key0", key_out, 16'h0000);
        chk("t4_busy0", {15'd0, busy}, 16'h0000);
        #1; chk("t4_rdy", {15'd0, note_ready}, 16'h0001);
        adv(1);
        note_valid = 1'b0;
        chk("t4_new", key_out, 16'h0080);
        abort = 1'b1; adv(1); abort = 1'b0;
        chk("t4_clr", key_out, 16'h0000);

        // 5: play_en gates acceptance only
        play_en = 1'b0; note_valid = 1'b1; note_code = 5'd9; note_beats = 4'd1;
        #1; chk("t5_nrdy", {15'd0, note_ready}, 16'h0000);
        adv(3); chk("t5_key", key_out, 16'h0000);
        chk("t5_nrdy3", {15'd0, note_ready}, 16'h0000);
        play_en = 1'b1;
        #1; chk("t5_rdy", {15'd0, note_ready}, 16'h0001);
        adv(1);
        note_valid = 1'b0;
        chk("t5_play", key_out, 16'h0200);
        play_en = 1'b0;
        adv(5); chk("t5_cont", key_out, 16'h0200);
        play_en = 1'b1;
        abort = 1'b1; adv(1); abort = 1'b0;

        // 6: back-to-back notes idx 0 then idx 1
        send("t6_acc0", 5'd0, 4'd1);                     // T+1
        note_valid = 1'b1; note_code = 5'd1; note_beats = 4'd1;
        chk("t6_n0", key_out, 16'h0001);
        #1; chk("t6_nrdy", {15'd0, note_ready}, 16'h0000);
        adv(11); chk("t6_n0end", key_out, 16'h0001);     // T+12
`ifdef BEEPER_SEQ_LEGATO_EN
        #1; chk("t6_lrdy", {15'd0, note_ready}, 16'h0001);
        adv(1);
        note_valid = 1'b0;
        chk("t6_n1", key_out, 16'h0002);                 // T+13
        adv(11); chk("t6_n1end", key_out, 16'h0002);
        adv(1);  chk("t6_idle", key_out, 16'h0000);
`else
        adv(1);  chk("t6_gap0", key_out, 16'h0000);      // T+13
        adv(7);  chk("t6_gap7", key_out, 16'h0000);      // T+20
        #1; chk("t6_grdy", {15'd0, note_ready}, 16'h0000);
        adv(1);                                          // T+21
        #1; chk("t6_rdy", {15'd0, note_ready}, 16'h0001);
        adv(1);
        note_valid = 1'b0;
        chk("t6_n1", key_out, 16'h0002);                 // T+22
        adv(11); chk("t6_n1end", key_out, 16'h0002);
        adv(1);  chk("t6_gap", key_out, 16'h0000);
`endif

        // 7: asynchronous reset mid-note clears at once
        abort = 1'b1; adv(1); abort = 1'b0;
        send("t7_acc", 5'd4, 4'd3);
        adv(3); chk("t7_play", key_out, 16'h0010);
        #1; rst_n_in = 1'b0;
        #1; chk("t7_key", key_out, 16'h0000);
        chk("t7_busy", {15'd0, busy}, 16'h0000);
        adv(1);
        rst_n_in = 1'b1;
        adv(1); chk("t7_stay", key_out, 16'h0000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
